// File: rtl/frequency_ratio_deserializer.sv
// frequency_ratio_deserializer: gathers 1/2/4 single-phase DFI beats into p0..p3 phase words
module frequency_ratio_deserializer #(
  parameter int NUM_RANK    = 2,
  parameter int DEVICE_TYPE = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [2:0]                 dfi_freq_ratio,
  input  logic [NUM_RANK-1:0]        dfi_cs_n,
  input  logic [NUM_RANK-1:0]        dfi_reset_n,
  input  logic [13:0]                dfi_address,
  input  logic                       dfi_wrdata_en,
  input  logic [2*DEVICE_TYPE-1:0]   dfi_wrdata,
  input  logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask,
  output logic [NUM_RANK-1:0]        dfi_cs_n_p0,
  output logic [NUM_RANK-1:0]        dfi_cs_n_p1,
  output logic [NUM_RANK-1:0]        dfi_cs_n_p2,
  output logic [NUM_RANK-1:0]        dfi_cs_n_p3,
  output logic [NUM_RANK-1:0]        dfi_reset_n_p0,
  output logic [NUM_RANK-1:0]        dfi_reset_n_p1,
  output logic [NUM_RANK-1:0]        dfi_reset_n_p2,
  output logic [NUM_RANK-1:0]        dfi_reset_n_p3,
  output logic [13:0]                dfi_address_p0,
  output logic [13:0]                dfi_address_p1,
  output logic [13:0]                dfi_address_p2,
  output logic [13:0]                dfi_address_p3,
  output logic                       dfi_wrdata_en_p0,
  output logic                       dfi_wrdata_en_p1,
  output logic                       dfi_wrdata_en_p2,
  output logic                       dfi_wrdata_en_p3,
  output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p0,
  output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p1,
  output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p2,
  output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p3,
  output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p0,
  output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p1,
  output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p2,
  output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p3,
  output logic                       o_valid,
  output logic                       o_ratio_err
);
  localparam int W = 2*NUM_RANK + 14 + 1 + 2*DEVICE_TYPE + DEVICE_TYPE/4;
  localparam logic [W-1:0] RST_BEAT = {{NUM_RANK{1'b1}}, {(W-NUM_RANK){1'b0}}};
  logic [W-1:0] beat;
  logic [W-1:0] stage [4];
  logic [W-1:0] outp [4];
  logic [1:0] cnt, lim, lim_held, new_lim;
  logic illegal, done;
  assign beat = {dfi_cs_n, dfi_reset_n, dfi_address, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask};
  // lim is the last phase index of the group: 0, 1 or 3
  always_comb begin
    illegal = dfi_freq_ratio > 3'b010;
    new_lim = dfi_freq_ratio == 3'b001 ? 2'd1 : dfi_freq_ratio == 3'b010 ? 2'd3 : 2'd0;
    lim = cnt == 2'd0 ? new_lim : lim_held;
    done = cnt == lim;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt <= 2'd0;
      lim_held <= 2'd0;
      o_valid <= 1'b0;
      o_ratio_err <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        stage[k] <= RST_BEAT;
        outp[k] <= RST_BEAT;
      end
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        cnt <= 2'd0;
      end else if (i_valid) begin
        stage[cnt] <= beat;
        if (cnt == 2'd0) lim_held <= new_lim;
        if (cnt == 2'd0 && illegal) o_ratio_err <= 1'b1;
        if (done) begin
          cnt <= 2'd0;
          o_valid <= 1'b1;
          // phases above the closing one are forced to reset values, never stale
          for (int k = 0; k < 4; k++)
            outp[k] <= k[1:0] == cnt ? beat : k[1:0] < cnt ? stage[k] : RST_BEAT;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end
  assign {dfi_cs_n_p0, dfi_reset_n_p0, dfi_address_p0, dfi_wrdata_en_p0, dfi_wrdata_p0, dfi_wrdata_mask_p0} = outp[0];
  assign {dfi_cs_n_p1, dfi_reset_n_p1, dfi_address_p1, dfi_wrdata_en_p1, dfi_wrdata_p1, dfi_wrdata_mask_p1} = outp[1];
  assign {dfi_cs_n_p2, dfi_reset_n_p2, dfi_address_p2, dfi_wrdata_en_p2, dfi_wrdata_p2, dfi_wrdata_mask_p2} = outp[2];
  assign {dfi_cs_n_p3, dfi_reset_n_p3, dfi_address_p3, dfi_wrdata_en_p3, dfi_wrdata_p3, dfi_wrdata_mask_p3} = outp[3];
endmodule

// File: tb/tb_frequency_ratio_deserializer.sv
// tb_frequency_ratio_deserializer: directed plus random stimulus against a queue-based group model
module tb_frequency_ratio_deserializer;
  typedef struct packed {
    logic [1:0]  cs;
    logic [1:0]  rn;
    logic [13:0] a;
    logic        en;
    logic [7:0]  d;
    logic        m;
  } beat_t;
  localparam beat_t RSTB = '{cs: 2'b11, rn: 2'b00, a: 14'h0, en: 1'b0, d: 8'h0, m: 1'b0};
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, val = 1'b0;
  logic [2:0] ratio = 3'b000;
  beat_t ib = '0;
  logic [1:0] ocs [4];
  logic [1:0] orn [4];
  logic [13:0] oa [4];
  logic oen [4];
  logic [7:0] od [4];
  logic om [4];
  logic o_valid, o_ratio_err;
  int tests = 0, fails = 0;
  beat_t q[$];
  int need = 1;
  bit m_err = 0, m_v = 0;
  beat_t m_p [4];
  always #5 clk = ~clk;
  frequency_ratio_deserializer dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(val), .dfi_freq_ratio(ratio),
    .dfi_cs_n(ib.cs), .dfi_reset_n(ib.rn), .dfi_address(ib.a), .dfi_wrdata_en(ib.en),
    .dfi_wrdata(ib.d), .dfi_wrdata_mask(ib.m),
    .dfi_cs_n_p0(ocs[0]), .dfi_cs_n_p1(ocs[1]), .dfi_cs_n_p2(ocs[2]), .dfi_cs_n_p3(ocs[3]),
    .dfi_reset_n_p0(orn[0]), .dfi_reset_n_p1(orn[1]), .dfi_reset_n_p2(orn[2]), .dfi_reset_n_p3(orn[3]),
    .dfi_address_p0(oa[0]), .dfi_address_p1(oa[1]), .dfi_address_p2(oa[2]), .dfi_address_p3(oa[3]),
    .dfi_wrdata_en_p0(oen[0]), .dfi_wrdata_en_p1(oen[1]), .dfi_wrdata_en_p2(oen[2]), .dfi_wrdata_en_p3(oen[3]),
    .dfi_wrdata_p0(od[0]), .dfi_wrdata_p1(od[1]), .dfi_wrdata_p2(od[2]), .dfi_wrdata_p3(od[3]),
    .dfi_wrdata_mask_p0(om[0]), .dfi_wrdata_mask_p1(om[1]), .dfi_wrdata_mask_p2(om[2]), .dfi_wrdata_mask_p3(om[3]),
    .o_valid(o_valid), .o_ratio_err(o_ratio_err)
  );
  function automatic beat_t obs(int k);
    return '{cs: ocs[k], rn: orn[k], a: oa[k], en: oen[k], d: od[k], m: om[k]};
  endfunction
  function automatic beat_t mk(logic [1:0] cs, logic [1:0] rn, logic [13:0] a, logic e, logic [7:0] d, logic m);
    return '{cs: cs, rn: rn, a: a, en: e, d: d, m: m};
  endfunction
  task automatic model();
    if (rst) begin
      q.delete(); need = 1; m_err = 0; m_v = 0;
      for (int k = 0; k < 4; k++) m_p[k] = RSTB;
    end else begin
      m_v = 0;
      if (!en) q.delete();
      else if (val) begin
        if (q.size() == 0) begin
          case (ratio)
            3'b000: need = 1;
            3'b001: need = 2;
            3'b010: need = 4;
            default: begin need = 1; m_err = 1; end
          endcase
        end
        q.push_back(ib);
        if (q.size() == need) begin
          for (int k = 0; k < 4; k++) m_p[k] = k < need ? q[k] : RSTB;
          m_v = 1;
          q.delete();
        end
      end
    end
  endtask
  task automatic check(string tag);
    tests++;
    assert (o_valid === m_v) else begin fails++; $error("FAIL %s o_valid got %0b want %0b", tag, o_valid, m_v); end
    tests++;
    assert (o_ratio_err === m_err) else begin fails++; $error("FAIL %s o_ratio_err got %0b want %0b", tag, o_ratio_err, m_err); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      assert (obs(k) === m_p[k]) else begin fails++; $error("FAIL %s p%0d got %h want %h", tag, k, obs(k), m_p[k]); end
    end
  endtask
  task automatic step(string tag, logic r, logic e, logic v, logic [2:0] rat, beat_t b);
    rst = r; en = e; val = v; ratio = rat; ib = b;
    @(posedge clk);
    model();
    #1;
    check(tag);
  endtask
  task automatic direct(string tag, logic [7:0] want, int k);
    tests++;
    assert (od[k] === want) else begin fails++; $error("FAIL %s p%0d wrdata got %h want %h", tag, k, od[k], want); end
  endtask
  initial begin
    beat_t z = '0;
    step("reset", 1, 0, 0, 3'b000, z);
    step("reset_hold", 1, 1, 1, 3'b010, mk(2'b00, 2'b11, 14'h123, 1, 8'hFF, 1));
    step("idle", 0, 1, 0, 3'b000, z);
    step("g4_b0", 0, 1, 1, 3'b010, mk(2'b01, 2'b11, 14'h0000, 1, 8'h01, 0));
    step("g4_b1", 0, 1, 1, 3'b010, mk(2'b10, 2'b01, 14'h3FFF, 0, 8'h02, 1));
    step("g4_b2", 0, 1, 1, 3'b010, mk(2'b00, 2'b00, 14'h2AAA, 0, 8'h03, 1));
    step("g4_b3", 0, 1, 1, 3'b010, mk(2'b11, 2'b10, 14'h1555, 1, 8'h04, 0));
    direct("g4_p3", 8'h04, 3);
    step("g4_after", 0, 1, 0, 3'b010, z);
    step("g2_b0", 0, 1, 1, 3'b001, mk(2'b00, 2'b11, 14'h11, 1, 8'hA5, 0));
    step("g2_bub", 0, 1, 0, 3'b001, z);
    step("g2_b1", 0, 1, 1, 3'b001, mk(2'b01, 2'b10, 14'h22, 0, 8'h5A, 1));
    direct("g2_p0", 8'hA5, 0);
    direct("g2_p1", 8'h5A, 1);
    step("chg_b0", 0, 1, 1, 3'b010, mk(2'b00, 2'b11, 14'h100, 1, 8'h10, 0));
    step("chg_b1", 0, 1, 1, 3'b010, mk(2'b01, 2'b11, 14'h101, 1, 8'h11, 0));
    step("chg_b2", 0, 1, 1, 3'b000, mk(2'b10, 2'b11, 14'h102, 1, 8'h12, 0));
    step("chg_b3", 0, 1, 1, 3'b000, mk(2'b11, 2'b11, 14'h103, 1, 8'h13, 0));
    step("g1_a", 0, 1, 1, 3'b000, mk(2'b00, 2'b01, 14'h200, 0, 8'h20, 1));
    step("g1_b", 0, 1, 1, 3'b000, mk(2'b01, 2'b01, 14'h201, 0, 8'h21, 1));
    for (int i = 0; i < 3; i++) step("fl_old", 0, 1, 1, 3'b010, mk(2'b00, 2'b00, 14'(i), 1, 8'hE0 + 8'(i), 1));
    step("fl_off", 0, 0, 1, 3'b010, z);
    for (int i = 0; i < 4; i++) step("fl_new", 0, 1, 1, 3'b010, mk(2'(i), 2'(3 - i), 14'h300 + 14'(i), 1'(i), 8'hC0 + 8'(i), 1'(i)));
    direct("fl_p0", 8'hC0, 0);
    for (int i = 0; i < 2; i++) step("rs_old", 0, 1, 1, 3'b010, mk(2'b00, 2'b00, 14'h7, 1, 8'h77, 1));
    step("rs_pulse", 1, 1, 1, 3'b010, z);
    for (int i = 0; i < 4; i++) step("rs_new", 0, 1, 1, 3'b010, mk(2'(i), 2'(i), 14'h400 + 14'(i), 1, 8'h90 + 8'(i), 0));
    step("ill_b", 0, 1, 1, 3'b101, mk(2'b10, 2'b01, 14'h55, 1, 8'h33, 0));
    direct("ill_p0", 8'h33, 0);
    step("ill_sticky", 0, 1, 1, 3'b000, mk(2'b01, 2'b01, 14'h56, 0, 8'h34, 0));
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r = $urandom_range(0, 19) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, r, beat_t'($urandom));
    end
    for (int i = 0; i < 8; i++) step("b2b4", 0, 1, 1, 3'b010, beat_t'($urandom));
    for (int i = 0; i < 3; i++) step("b2b1", 0, 1, 1, 3'b000, beat_t'($urandom));
    step("final_rst", 1, 0, 0, 3'b000, z);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
